// File: rtl/range_seq_checker_if.sv
// Sample stream handshake between a producer and the range/sequence checker.
// The producer drives the master side, the checker sits on the slave side.
interface range_seq_checker_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/range_seq_checker.sv
// Checks an incoming sample stream against an arithmetic sequence
// start, start+step, ... <= stop, and enforces a minimum inter-sample gap.
module range_seq_checker #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [W-1:0]     cfg_start,
    input  logic [W-1:0]     cfg_stop,
    input  logic [W-1:0]     cfg_step,
    input  logic [CNT_W-1:0] cfg_min_gap,
    range_seq_checker_if.slave sample,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             cfg_err,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] gap_err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [W-1:0]     first_err_exp,
    output logic [W-1:0]     first_err_got
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state;
    logic [W-1:0]     stop_q;
    logic [W-1:0]     step_q;
    logic [W-1:0]     exp_q;
    logic [CNT_W-1:0] gap_min_q;
    logic [CNT_W-1:0] gap_q;
    logic             first_q;

    logic             accept;
    logic             mismatch;
    logic             gap_viol;
    logic             last;
    logic [W:0]       next_sum;

    assign sample.in_ready = (state == CHECK);
    assign busy            = (state == CHECK);

    assign accept   = sample.in_valid && (state == CHECK);
    assign mismatch = (sample.in_data != exp_q);
    assign gap_viol = !first_q && (gap_q < gap_min_q);
    assign next_sum = {1'b0, exp_q} + {1'b0, step_q};
    // Carry out of bit W means the sequence wrapped: treat as past stop.
    assign last     = next_sum[W] || (next_sum[W-1:0] > stop_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            stop_q        <= '0;
            step_q        <= '0;
            exp_q         <= '0;
            gap_min_q     <= '0;
            gap_q         <= '0;
            first_q       <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            cfg_err       <= 1'b0;
            sample_count  <= '0;
            err_count     <= '0;
            gap_err_count <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        stop_q        <= cfg_stop;
                        step_q        <= cfg_step;
                        gap_min_q     <= cfg_min_gap;
                        exp_q         <= cfg_start;
                        gap_q         <= '0;
                        first_q       <= 1'b1;
                        pass          <= 1'b0;
                        sample_count  <= '0;
                        err_count     <= '0;
                        gap_err_count <= '0;
                        first_err_idx <= '0;
                        first_err_exp <= '0;
                        first_err_got <= '0;
                        if (cfg_step == '0 || cfg_start > cfg_stop) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            cfg_err <= 1'b1;
                        end else begin
                            state   <= CHECK;
                            done    <= 1'b0;
                            cfg_err <= 1'b0;
                        end
                    end
                end
                CHECK: begin
                    if (!accept && gap_q != CMAX) begin
                        gap_q <= gap_q + ONE;
                    end
                    if (accept) begin
                        if (mismatch) begin
                            if (err_count == '0) begin
                                first_err_idx <= sample_count;
                                first_err_exp <= exp_q;
                                first_err_got <= sample.in_data;
                            end
                            if (err_count != CMAX) begin
                                err_count <= err_count + ONE;
                            end
                        end
                        if (sample_count != CMAX) begin
                            sample_count <= sample_count + ONE;
                        end
                        if (gap_viol && gap_err_count != CMAX) begin
                            gap_err_count <= gap_err_count + ONE;
                        end
                        gap_q   <= ONE;
                        first_q <= 1'b0;
                        exp_q   <= next_sum[W-1:0];
                        if (last) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= (err_count == '0) && !mismatch &&
                                     (gap_err_count == '0) && !gap_viol;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_range_seq_checker.sv
// Randomized and directed bench for range_seq_checker, compared against a
// sequence-list model evaluated once per clock.
module tb_range_seq_checker;
    localparam int W  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          arm;
    logic [W-1:0]  cfg_start;
    logic [W-1:0]  cfg_stop;
    logic [W-1:0]  cfg_step;
    logic [CW-1:0] cfg_min_gap;
    logic          busy, done, pass, cfg_err;
    logic [CW-1:0] sample_count, err_count, gap_err_count, first_err_idx;
    logic [W-1:0]  first_err_exp, first_err_got;

    range_seq_checker_if #(.W(W)) bus ();

    range_seq_checker #(.W(W), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .arm           (arm),
        .cfg_start     (cfg_start),
        .cfg_stop      (cfg_stop),
        .cfg_step      (cfg_step),
        .cfg_min_gap   (cfg_min_gap),
        .sample        (bus.slave),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .cfg_err       (cfg_err),
        .sample_count  (sample_count),
        .err_count     (err_count),
        .gap_err_count (gap_err_count),
        .first_err_idx (first_err_idx),
        .first_err_exp (first_err_exp),
        .first_err_got (first_err_got)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 running, 2 finished
    int     m_st = 0;
    longint m_seq[$];
    int     m_pos;
    longint m_cnt, m_err, m_gerr, m_fidx, m_fexp, m_fgot;
    longint m_gap_min, m_last, cyc = 0;
    bit     m_first, m_done, m_pass, m_cfgerr;

    localparam longint SAT = 65535;

    task automatic m_clear();
        m_cnt = 0; m_err = 0; m_gerr = 0;
        m_fidx = 0; m_fexp = 0; m_fgot = 0;
        m_pass = 0; m_cfgerr = 0; m_done = 0;
        m_pos = 0; m_first = 1; m_seq.delete();
    endtask

    task automatic model_edge();
        longint gap, e;
        cyc++;
        if (rst) begin
            m_clear();
            m_st = 0;
        end else if (arm && m_st != 1) begin
            m_clear();
            m_gap_min = cfg_min_gap;
            if (cfg_step == 0 || cfg_start > cfg_stop) begin
                m_st = 2; m_done = 1; m_cfgerr = 1;
            end else begin
                for (longint x = cfg_start; x <= cfg_stop; x += cfg_step)
                    m_seq.push_back(x);
                m_st = 1;
            end
        end else if (m_st == 1 && bus.in_valid) begin
            e = m_seq[m_pos];
            if (bus.in_data != e) begin
                if (m_err == 0) begin
                    m_fidx = m_cnt; m_fexp = e; m_fgot = bus.in_data;
                end
                if (m_err < SAT) m_err++;
            end
            gap = cyc - m_last;
            if (gap > SAT) gap = SAT;
            if (!m_first && gap < m_gap_min && m_gerr < SAT) m_gerr++;
            m_last = cyc;
            m_first = 0;
            if (m_cnt < SAT) m_cnt++;
            m_pos++;
            if (m_pos == m_seq.size()) begin
                m_st = 2; m_done = 1;
                m_pass = (m_err == 0 && m_gerr == 0);
            end
        end
    endtask

    function automatic logic [W-1:0] exp_now();
        if (m_st == 1 && m_pos < m_seq.size()) return W'(m_seq[m_pos]);
        return '0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", bus.in_ready, m_st == 1);
            chk("busy", busy, m_st == 1);
            chk("done", done, m_done);
            chk("pass", pass, m_pass);
            chk("cfg_err", cfg_err, m_cfgerr);
            chk("sample_count", sample_count, m_cnt);
            chk("err_count", err_count, m_err);
            chk("gap_err_count", gap_err_count, m_gerr);
            chk("first_err_idx", first_err_idx, m_fidx);
            chk("first_err_exp", first_err_exp, m_fexp);
            chk("first_err_got", first_err_got, m_fgot);
        end
    end

    task automatic tick(input bit a, input bit v, input logic [W-1:0] d, input bit r);
        arm = a; bus.in_valid = v; bus.in_data = d; rst = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_cfg(input int s, input int e, input int st, input int g);
        cfg_start = W'(s); cfg_stop = W'(e); cfg_step = W'(st); cfg_min_gap = CW'(g);
    endtask

    initial begin
        rst = 1; arm = 0; bus.in_valid = 0; bus.in_data = '0;
        set_cfg(0, 0, 0, 0);
        @(negedge clk);
        tick(0, 0, 0, 1);
        chk_en = 1;
        chk("rst_done", done, 0);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_cnt", sample_count, 0);

        // 16 back-to-back correct samples
        set_cfg(0, 15, 1, 0);
        tick(1, 0, 0, 0);
        chk("r39_busy", busy, 1);
        for (int i = 0; i < 16; i++) tick(0, 1, W'(i), 0);
        chk("r39_cnt", sample_count, 16);
        chk("r39_done", done, 1);
        chk("r39_pass", pass, 1);

        // one mismatch at index 2
        set_cfg(10, 50, 10, 0);
        tick(1, 0, 0, 0);
        tick(0, 1, 10, 0); tick(0, 1, 20, 0);
        tick(0, 1, 31, 0); tick(0, 1, 40, 0);
        chk("r40_notdone", done, 0);
        tick(0, 1, 50, 0);
        chk("r40_done", done, 1);
        chk("r40_err", err_count, 1);
        chk("r40_idx", first_err_idx, 2);
        chk("r40_exp", first_err_exp, 30);
        chk("r40_got", first_err_got, 31);
        chk("r40_pass", pass, 0);

        // gap violation, then a clean spaced run
        set_cfg(0, 7, 1, 3);
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0); tick(0, 1, 1, 0);
        chk("r41_gerr_b2b", gap_err_count, 1);
        for (int i = 2; i < 8; i++) begin
            tick(0, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 1, W'(i), 0);
        end
        chk("r41_gerr_a", gap_err_count, 1);
        chk("r41_pass_a", pass, 0);
        tick(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, W'(i), 0);
            if (i < 7) begin tick(0, 0, 0, 0); tick(0, 0, 0, 0); end
        end
        chk("r41_gerr_b", gap_err_count, 0);
        chk("r41_pass_b", pass, 1);

        // end of sequence by exceeding stop, then by W-bit overflow
        set_cfg(250, 255, 4, 0);
        tick(1, 0, 0, 0);
        tick(0, 1, 250, 0);
        chk("r42a_notdone", done, 0);
        tick(0, 1, 254, 0);
        chk("r42a_done", done, 1);
        chk("r42a_cnt", sample_count, 2);
        set_cfg(252, 255, 8, 0);
        tick(1, 0, 0, 0);
        tick(0, 1, 252, 0);
        chk("r42b_done", done, 1);
        chk("r42b_cnt", sample_count, 1);

        // rejected configurations
        set_cfg(0, 10, 0, 0);
        tick(1, 0, 0, 0);
        chk("r43a_cfgerr", cfg_err, 1);
        chk("r43a_done", done, 1);
        chk("r43a_ready", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
        chk("r43a_cnt", sample_count, 0);
        set_cfg(5, 4, 1, 0);
        tick(1, 0, 0, 0);
        chk("r43b_cfgerr", cfg_err, 1);
        chk("r43b_pass", pass, 0);
        tick(0, 1, 5, 0);
        chk("r43b_ready", bus.in_ready, 0);

        // reset mid-run with arm, then full re-run
        set_cfg(0, 7, 1, 0);
        tick(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 1, W'(i), 0);
        tick(1, 0, 0, 1);
        chk("r44_busy", busy, 0);
        chk("r44_cnt", sample_count, 0);
        chk("r44_done", done, 0);
        tick(1, 0, 0, 0);
        tick(1, 1, 0, 0);
        for (int i = 1; i < 8; i++) tick(0, 1, W'(i), 0);
        chk("r44_cnt8", sample_count, 8);
        chk("r44_pass", pass, 1);

        // randomized runs
        for (int r = 0; r < 60; r++) begin
            int s, e, st;
            s  = $urandom_range(0, 255);
            e  = ($urandom % 5 == 0) ? $urandom_range(0, 255) : s + $urandom_range(0, 255 - s);
            st = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 40);
            set_cfg(s, e, st, $urandom_range(0, 4));
            tick(1, 0, 0, 0);
            for (int c = 0; c < 500 && m_st == 1; c++) begin
                logic [W-1:0] d;
                d = ($urandom % 6 == 0) ? W'($urandom) : exp_now();
                tick($urandom % 20 == 0, $urandom % 3 != 0, d, $urandom % 400 == 0);
            end
            if (m_st == 1) tick(0, 0, 0, 1);
            tick(0, $urandom % 2 == 1, W'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/range_seq_checker.md
RANGE_SEQ_CHECKER -- requirements
Module: range_seq_checker

Interface
REQ-001 Parameter W, default 32: width of data and range config.
REQ-002 Parameter CNT_W, default 16: width of all counters and gap config.
REQ-003 Port clk  input  1: single clock; all logic on rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port arm  input  1: one-cycle pulse; latches config and starts a check run.
REQ-006 Port cfg_start  input  W: first expected value, unsigned.
REQ-007 Port cfg_stop  input  W: last value, inclusive, unsigned.
REQ-008 Port cfg_step  input  W: increment, unsigned, nonzero.
REQ-009 Port cfg_min_gap  input  CNT_W: minimum clk cycles between consecutive accepted samples.
REQ-010 Port in_valid  input  1: sample present.
REQ-011 Port in_data  input  W: sample value.
REQ-012 Port in_ready  output  1: checker accepts the sample this cycle.
REQ-013 Port busy  output  1: run in progress.
REQ-014 Port done  output  1: run finished; held until next arm or rst.
REQ-015 Port pass  output  1: valid when done; 1 = no value, gap or config error.
REQ-016 Port cfg_err  output  1: config rejected (step==0 or start>stop).
REQ-017 Port sample_count  output  CNT_W: samples accepted this run.
REQ-018 Port err_count  output  CNT_W: value mismatches this run, saturating.
REQ-019 Port gap_err_count  output  CNT_W: gap violations this run, saturating.
REQ-020 Port first_err_idx / first_err_exp / first_err_got  output  CNT_W / W / W: index, expected value and received value of the first mismatch.

Function
REQ-021 The FSM SHALL have states IDLE, CHECK, DONE; in_ready = (state==CHECK) and busy = (state==CHECK), both decoded from registered state only.
REQ-022 In IDLE or DONE, arm SHALL latch cfg_*, clear all counters, first_err_*, cfg_err, done and pass, and load expected=cfg_start.
REQ-023 On arm with cfg_step==0 or cfg_start>cfg_stop, the block SHALL go to DONE next cycle with cfg_err=1 and pass=0, and accept no samples.
REQ-024 Otherwise arm SHALL enter CHECK on the next cycle.
REQ-025 arm during CHECK SHALL be ignored.
REQ-026 An accept is in_valid && in_ready; only accepts update state.
REQ-027 On accept, in_data!=expected SHALL increment err_count (saturating at 2**CNT_W-1); the first mismatch SHALL capture first_err_* with idx = sample_count before increment.
REQ-028 On accept, sample_count SHALL increment, saturating at 2**CNT_W-1.
REQ-029 The gap counter SHALL count cycles since the previous accept, saturating at 2**CNT_W-1. It SHALL NOT be checked for the first accept of a run.
REQ-030 For a later accept, a gap count < cfg_min_gap SHALL increment gap_err_count (saturating). The gap counter SHALL reset so that back-to-back accepts measure gap=1.
REQ-031 The next expected value SHALL be computed as expected+step in W+1 bits. If the sum > stop or overflows bit W, this accept is the last sample.
REQ-032 After the last sample, the block SHALL enter DONE on the next cycle with done=1. pass = (err_count==0 && gap_err_count==0), including the final sample's result.
REQ-033 All count and first_err updates SHALL be visible the cycle after the accept (1-cycle latency).
REQ-034 A mismatch SHALL NOT resynchronize expected; the sequence advances by step regardless of data.
REQ-035 in_valid outside CHECK SHALL be ignored, with no counter change.

Reset
REQ-036 rst SHALL force IDLE from any state, including mid-run, on the next edge.
REQ-037 rst SHALL clear every output to 0, including pass and cfg_err.
REQ-038 rst SHALL take priority over arm in the same cycle.

Verification
REQ-039 start=0, stop=15, step=1, min_gap=0, 16 back-to-back correct samples -> sample_count=16, err=0, done=1, pass=1 one cycle after the 16th accept.
REQ-040 start=10, stop=50, step=10, 3rd sample 31 -> err_count=1, first_err idx=2 / exp=30 / got=31, done after 5 samples, pass=0.
REQ-041 start=0, stop=7, step=1, min_gap=3, two samples one cycle apart -> gap_err_count=1, pass=0; same run with samples 3 cycles apart -> gap_err_count=0.
REQ-042 W=8, start=250, stop=255, step=4 -> done after samples 250 and 254 (258 exceeds stop); W=8, start=252, stop=255, step=8 -> done after 1 sample (overflow).
REQ-043 arm with step=0, and arm with start=5/stop=4 -> DONE next cycle with cfg_err=1, pass=0, in_ready never 1.
REQ-044 rst asserted after 3 of 8 samples with arm held high in the same cycle -> IDLE, all outputs 0; a re-arm then checks the full sequence from cfg_start.
